// File: rtl/block_detector_frame_ctrl.sv
// Frame sequencer between the video AXI4-Stream input and the block detector:
// gates whole frames, generates coordinates, checks geometry and latches results.
module block_detector_frame_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned XW     = 11,
  parameter int unsigned YW     = 11
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_continuous,
  input  logic [XW-1:0]     cfg_width,
  input  logic [YW-1:0]     cfg_height,
  input  logic              irq_clear,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              det_frame_start,
  output logic [XW-1:0]     det_x,
  output logic [YW-1:0]     det_y,
  input  logic [XW-1:0]     det_xmin,
  input  logic [XW-1:0]     det_xmax,
  input  logic [YW-1:0]     det_ymin,
  input  logic [YW-1:0]     det_ymax,
  input  logic              det_found,
  output logic [XW-1:0]     res_xmin,
  output logic [XW-1:0]     res_xmax,
  output logic [YW-1:0]     res_ymin,
  output logic [YW-1:0]     res_ymax,
  output logic              res_found,
  output logic              res_valid,
  output logic              irq,
  output logic              busy,
  output logic              err_line_len,
  output logic              err_early_sof,
  output logic [15:0]       frame_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOF = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]    state, stateNext;
  logic [XW-1:0] xCnt, xNext, xCur, xLast;
  logic [YW-1:0] yCnt, yNext, yCur, yLast;
  logic          passThru, accept, sofBeat, frameEnd, lineErr, earlySof;

  assign xLast = cfg_width - XW'(1);
  assign yLast = cfg_height - YW'(1);

  // Next state, stream gating and coordinate update
  always_comb begin
    stateNext     = state;
    passThru      = 1'b0;
    s_axis_tready = 1'b1;
    case (state)
      IDLE:     if (cfg_start) stateNext = WAIT_SOF;
      WAIT_SOF: passThru = s_axis_tvalid & s_axis_tuser;
      ACTIVE:   passThru = 1'b1;
      DONE: begin
        s_axis_tready = 1'b0;
        stateNext     = cfg_continuous ? WAIT_SOF : IDLE;
      end
      default:  stateNext = IDLE;
    endcase
    if (passThru) s_axis_tready = m_axis_tready;

    accept   = passThru & s_axis_tvalid & m_axis_tready;
    sofBeat  = passThru & s_axis_tvalid & s_axis_tuser;
    // A start-of-frame beat always sits at (0,0), whatever the counters held
    xCur     = sofBeat ? '0 : xCnt;
    yCur     = sofBeat ? '0 : yCnt;
    frameEnd = accept & s_axis_tlast & (yCur == yLast);
    lineErr  = accept & (s_axis_tlast ? (xCur != xLast) : (xCur == xLast));
    earlySof = accept & s_axis_tuser & (state == ACTIVE);

    xNext = xCnt;
    yNext = yCnt;
    if (accept) begin
      if (s_axis_tlast) begin
        xNext = '0;
        yNext = yCur + YW'(1);
      end else begin
        xNext = (xCur == xLast) ? xCur : xCur + XW'(1);
        yNext = yCur;
      end
      if (state == WAIT_SOF) stateNext = ACTIVE;
    end
    if (frameEnd) stateNext = DONE;
    if (cfg_stop) stateNext = IDLE;
    if (stateNext != ACTIVE) begin
      xNext = '0;
      yNext = '0;
    end
  end

  assign m_axis_tdata    = s_axis_tdata;
  assign m_axis_tvalid   = passThru & s_axis_tvalid;
  assign m_axis_tuser    = s_axis_tuser;
  assign m_axis_tlast    = s_axis_tlast;
  assign det_frame_start = accept & s_axis_tuser;
  assign det_x           = xCur;
  assign det_y           = yCur;
  assign busy            = (state != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      xCnt          <= '0;
      yCnt          <= '0;
      res_xmin      <= '0;
      res_xmax      <= '0;
      res_ymin      <= '0;
      res_ymax      <= '0;
      res_found     <= 1'b0;
      res_valid     <= 1'b0;
      irq           <= 1'b0;
      err_line_len  <= 1'b0;
      err_early_sof <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state <= stateNext;
      xCnt  <= xNext;
      yCnt  <= yNext;
      if (irq_clear) begin
        irq           <= 1'b0;
        err_line_len  <= 1'b0;
        err_early_sof <= 1'b0;
      end
      if (lineErr)  err_line_len  <= 1'b1;
      if (earlySof) err_early_sof <= 1'b1;
      // Detector has had a full cycle since the last beat; sample its accumulators
      if (state == DONE && !cfg_stop) begin
        res_xmin  <= det_xmin;
        res_xmax  <= det_xmax;
        res_ymin  <= det_ymin;
        res_ymax  <= det_ymax;
        res_found <= det_found;
        res_valid <= 1'b1;
        irq       <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_block_detector_frame_ctrl.sv
// Directed bench for block_detector_frame_ctrl: frame gating, coordinates,
// backpressure, geometry errors, early SOF, continuous mode and stop.
module tb_block_detector_frame_ctrl;

  logic        tb_ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_start, cfg_stop, cfg_continuous, irq_clear;
  logic [10:0] cfg_width, cfg_height;
  logic [31:0] s_axis_tdata, m_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
  logic        det_frame_start, det_found;
  logic [10:0] det_x, det_y, det_xmin, det_xmax, det_ymin, det_ymax;
  logic [10:0] res_xmin, res_xmax, res_ymin, res_ymax;
  logic        res_found, res_valid, irq, busy, err_line_len, err_early_sof;
  logic [15:0] frame_cnt;

  int vecCnt = 0;
  int errCnt = 0;
  int outBeats = 0;

  block_detector_frame_ctrl dut (
    .ACLK(tb_ACLK), .ARESET(ARESET),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_continuous(cfg_continuous),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .irq_clear(irq_clear),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .det_frame_start(det_frame_start), .det_x(det_x), .det_y(det_y),
    .det_xmin(det_xmin), .det_xmax(det_xmax), .det_ymin(det_ymin), .det_ymax(det_ymax),
    .det_found(det_found),
    .res_xmin(res_xmin), .res_xmax(res_xmax), .res_ymin(res_ymin), .res_ymax(res_ymax),
    .res_found(res_found), .res_valid(res_valid), .irq(irq), .busy(busy),
    .err_line_len(err_line_len), .err_early_sof(err_early_sof), .frame_cnt(frame_cnt)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  always @(posedge tb_ACLK)
    if (!ARESET && m_axis_tvalid && m_axis_tready) outBeats++;

  initial begin
    #200000;
    $display("FAIL watchdog: run time exceeded, got timeout, want $finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic doReset();
    ARESET = 1'b1;
    cfg_start = 0; cfg_stop = 0; irq_clear = 0;
    s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0; s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0;
  endtask

  task automatic pulseStart();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic setDet(input int xmn, input int xmx, input int ymn, input int ymx, input logic f);
    det_xmin = 11'(xmn); det_xmax = 11'(xmx);
    det_ymin = 11'(ymn); det_ymax = 11'(ymx); det_found = f;
  endtask

  // Non-SOF beat that must be swallowed (IDLE or WAIT_SOF)
  task automatic junkBeat();
    s_axis_tvalid = 1; s_axis_tuser = 0; s_axis_tlast = 0; s_axis_tdata = $urandom;
    @(negedge tb_ACLK);
    checkVal("junk_tready", s_axis_tready, 1);
    checkVal("junk_mvalid", m_axis_tvalid, 0);
    checkVal("junk_fstart", det_frame_start, 0);
    tick();
    s_axis_tvalid = 0;
  endtask

  // One frame beat; with bp the sink ready toggles every cycle
  task automatic frameBeat(input logic user, input logic last, input int ex, input int ey, input logic bp);
    logic [31:0] d;
    bit taken;
    taken = 0;
    d = $urandom;
    s_axis_tvalid = 1; s_axis_tuser = user; s_axis_tlast = last; s_axis_tdata = d;
    for (int t = 0; t < 4 && !taken; t++) begin
      if (bp) m_axis_tready = ~m_axis_tready;
      @(negedge tb_ACLK);
      checkVal("tready", s_axis_tready, m_axis_tready);
      checkVal("mvalid", m_axis_tvalid, 1);
      checkVal("tdata", m_axis_tdata, d);
      checkVal("mlast", m_axis_tlast, last);
      checkVal("det_x", det_x, ex);
      checkVal("det_y", det_y, ey);
      checkVal("fstart", det_frame_start, user & m_axis_tready);
      taken = m_axis_tready;
      tick();
    end
    if (!taken) checkVal("accept", 0, 1);
    s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
  endtask

  task automatic runFrame(input int w, input int h, input logic bp);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        frameBeat(x == 0 && y == 0, x == w - 1, x, y, bp);
  endtask

  // The single DONE bubble; a pending beat must be held off
  task automatic doneCycle();
    s_axis_tvalid = 1; s_axis_tuser = 0; s_axis_tdata = $urandom;
    @(negedge tb_ACLK);
    checkVal("done_tready", s_axis_tready, 0);
    checkVal("done_mvalid", m_axis_tvalid, 0);
    checkVal("done_busy", busy, 1);
    tick();
    s_axis_tvalid = 0;
  endtask

  task automatic checkRes(input string tag, input int xmn, input int xmx, input int ymn, input int ymx, input logic f);
    checkVal({tag, "_xmin"}, res_xmin, xmn);
    checkVal({tag, "_xmax"}, res_xmax, xmx);
    checkVal({tag, "_ymin"}, res_ymin, ymn);
    checkVal({tag, "_ymax"}, res_ymax, ymx);
    checkVal({tag, "_found"}, res_found, f);
  endtask

  initial begin
    cfg_continuous = 0; cfg_width = 11'd4; cfg_height = 11'd3;
    setDet(1, 2, 0, 1, 1);
    doReset();

    // Reset state
    @(negedge tb_ACLK);
    checkVal("rst_tready", s_axis_tready, 1);
    checkVal("rst_mvalid", m_axis_tvalid, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_irq", irq, 0);
    checkVal("rst_rvalid", res_valid, 0);
    checkVal("rst_fcnt", frame_cnt, 0);
    checkVal("rst_errs", {err_line_len, err_early_sof}, 0);
    checkVal("rst_xy", {det_x, det_y}, 0);
    checkVal("rst_fstart", det_frame_start, 0);
    checkRes("rst", 0, 0, 0, 0, 0);
    tick();

    // IDLE drains, then junk ahead of SOF, then a 4x3 one-shot frame
    junkBeat();
    pulseStart();
    checkVal("arm_busy", busy, 1);
    outBeats = 0;
    repeat (3) junkBeat();
    runFrame(4, 3, 0);
    checkVal("f1_irq_pre", irq, 0);
    doneCycle();
    checkVal("f1_beats", outBeats, 12);
    checkRes("f1", 1, 2, 0, 1, 1);
    checkVal("f1_irq", irq, 1);
    checkVal("f1_rvalid", res_valid, 1);
    checkVal("f1_fcnt", frame_cnt, 1);
    checkVal("f1_idle", busy, 0);
    checkVal("f1_err", err_line_len, 0);

    // Backpressure on a 4x2 frame
    cfg_height = 11'd2;
    setDet(3, 3, 1, 1, 0);
    pulseStart();
    outBeats = 0;
    runFrame(4, 2, 1);
    m_axis_tready = 1'b1;
    doneCycle();
    checkVal("bp_beats", outBeats, 8);
    checkVal("bp_fcnt", frame_cnt, 2);
    checkRes("bp", 3, 3, 1, 1, 0);
    checkVal("bp_err", err_line_len, 0);

    // Short first line (tlast at column 2) of a 4x3 frame
    cfg_height = 11'd3;
    setDet(0, 3, 0, 2, 1);
    pulseStart();
    frameBeat(1, 0, 0, 0, 0);
    frameBeat(0, 0, 1, 0, 0);
    frameBeat(0, 1, 2, 0, 0);
    checkVal("short_err", err_line_len, 1);
    for (int y = 1; y < 3; y++)
      for (int x = 0; x < 4; x++)
        frameBeat(0, x == 3, x, y, 0);
    doneCycle();
    checkVal("short_fcnt", frame_cnt, 3);
    checkVal("short_irq", irq, 1);
    checkVal("short_esof", err_early_sof, 0);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checkVal("clr_irq", irq, 0);
    checkVal("clr_err", err_line_len, 0);
    checkVal("clr_rvalid", res_valid, 1);
    checkRes("clr", 0, 3, 0, 2, 1);

    // Early SOF on beat 6 restarts the frame
    doReset();
    setDet(2, 3, 1, 2, 1);
    pulseStart();
    frameBeat(1, 0, 0, 0, 0);
    frameBeat(0, 0, 1, 0, 0);
    frameBeat(0, 0, 2, 0, 0);
    frameBeat(0, 1, 3, 0, 0);
    frameBeat(0, 0, 0, 1, 0);
    frameBeat(1, 0, 0, 0, 0);
    checkVal("esof_flag", err_early_sof, 1);
    checkVal("esof_rvalid", res_valid, 0);
    checkVal("esof_fcnt0", frame_cnt, 0);
    for (int i = 1; i < 12; i++)
      frameBeat(0, (i % 4) == 3, i % 4, i / 4, 0);
    doneCycle();
    checkVal("esof_fcnt", frame_cnt, 1);
    checkVal("esof_irq", irq, 1);
    checkRes("esof", 2, 3, 1, 2, 1);

    // Continuous mode: two frames back to back, stop mid third
    doReset();
    cfg_continuous = 1'b1;
    setDet(5, 9, 3, 7, 1);
    pulseStart();
    runFrame(4, 3, 0);
    doneCycle();
    checkVal("c1_fcnt", frame_cnt, 1);
    checkVal("c1_busy", busy, 1);
    checkRes("c1", 5, 9, 3, 7, 1);
    setDet(6, 10, 4, 8, 0);
    runFrame(4, 3, 0);
    doneCycle();
    checkVal("c2_fcnt", frame_cnt, 2);
    setDet(7, 7, 7, 7, 1);
    frameBeat(1, 0, 0, 0, 0);
    frameBeat(0, 0, 1, 0, 0);
    frameBeat(0, 0, 2, 0, 0);
    checkVal("c3_busy", busy, 1);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    checkVal("stop_busy", busy, 0);
    checkVal("stop_fcnt", frame_cnt, 2);
    checkRes("stop", 6, 10, 4, 8, 0);
    s_axis_tvalid = 1; s_axis_tuser = 1;
    @(negedge tb_ACLK);
    checkVal("stop_tready", s_axis_tready, 1);
    checkVal("stop_mvalid", m_axis_tvalid, 0);
    tick();
    s_axis_tvalid = 0; s_axis_tuser = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
